// File: rtl/list_walker.sv
// rtl/list_walker.sv - linked-list traversal sequencer producing payload sum and node count
// Each node takes two busy cycles: one to read the payload, one to read the next pointer.
module list_walker #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_NODES  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] head_addr,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  node_count,
  output logic [DATA_WIDTH-1:0] sum
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_PAY  = 2'd1;
  localparam logic [1:0] S_RD_NEXT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_NODES);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] count_inc;

  assign count_inc = node_count + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      err        <= 1'b0;
      node_count <= '0;
      sum        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sum        <= '0;
            node_count <= '0;
            err        <= 1'b0;
            if (head_addr != '0) begin
              mem_addr <= head_addr;
              state    <= S_RD_PAY;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_RD_PAY: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            sum      <= sum + mem_data;
            mem_addr <= mem_addr + DATA_WIDTH'(1);
            state    <= S_RD_NEXT;
          end
        end
        S_RD_NEXT: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            node_count <= count_inc;
            // A null pointer wins over the node limit: a list of exactly MAX_NODES is not an error.
            if (mem_data == '0) begin
              state <= S_DONE;
            end else if (count_inc == MAX_CNT) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              mem_addr <= mem_data;
              state    <= S_RD_PAY;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == S_RD_PAY) || (state == S_RD_NEXT);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_list_walker.sv
// tb/tb_list_walker.sv - directed self-checking bench for list_walker
module tb_list_walker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] head_addr;
  logic        abort;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] node_count;
  logic [31:0] sum;

  logic [31:0] mem [0:63];
  logic [31:0] trace [0:7];
  int          n_trace;
  int          checks = 0;
  int          errors = 0;
  int          done_cyc;
  int          busy_cnt;
  int          done_seen;

  always #5 clk = ~clk;

  assign mem_data = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'd0;

  list_walker #(.DATA_WIDTH(32), .MAX_NODES(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .head_addr(head_addr), .abort(abort),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done), .err(err),
    .node_count(node_count), .sum(sum)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a walk and samples every cycle on the falling edge until done or budget runs out.
  task automatic walk(input logic [31:0] head);
    @(negedge clk);
    start = 1'b1;
    head_addr = head;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = 0;
    busy_cnt = 0;
    n_trace = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (n_trace < 8) begin
          trace[n_trace] = mem_addr;
          n_trace++;
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[10] = 32'd5;  mem[11] = 32'd20;
    mem[20] = 32'd7;  mem[21] = 32'd30;
    mem[30] = 32'd9;  mem[31] = 32'd0;
    mem[40] = 32'd1;  mem[41] = 32'd40;
    mem[50] = 32'hFFFF_FFFF; mem[51] = 32'd52;
    mem[52] = 32'd2;  mem[53] = 32'd0;

    rst_n = 1'b0; start = 1'b0; head_addr = 32'd0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(node_count), 32'd0);
    check("rst_sum", sum, 32'd0);
    check("rst_addr", mem_addr, 32'd0);

    walk(32'd10);
    check("l3_done_cyc", 32'(done_cyc), 32'd7);
    check("l3_sum", sum, 32'd21);
    check("l3_cnt", 32'(node_count), 32'd3);
    check("l3_err", 32'(err), 32'd0);
    check("l3_ntrace", 32'(n_trace), 32'd6);
    check("l3_a0", trace[0], 32'd10);
    check("l3_a1", trace[1], 32'd11);
    check("l3_a2", trace[2], 32'd20);
    check("l3_a3", trace[3], 32'd21);
    check("l3_a4", trace[4], 32'd30);
    check("l3_a5", trace[5], 32'd31);
    @(negedge clk);
    check("l3_done_pulse", 32'(done), 32'd0);
    check("l3_idle_sum", sum, 32'd21);
    check("l3_hold_addr", mem_addr, 32'd31);

    walk(32'd0);
    check("empty_done_cyc", 32'(done_cyc), 32'd1);
    check("empty_busy", 32'(busy_cnt), 32'd0);
    check("empty_sum", sum, 32'd0);
    check("empty_cnt", 32'(node_count), 32'd0);
    check("empty_err", 32'(err), 32'd0);

    walk(32'd40);
    check("loop_done_cyc", 32'(done_cyc), 32'd9);
    check("loop_cnt", 32'(node_count), 32'd4);
    check("loop_sum", sum, 32'd4);
    check("loop_err", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("loop_err_hold", 32'(err), 32'd1);

    walk(32'd50);
    check("wrap_done_cyc", 32'(done_cyc), 32'd5);
    check("wrap_sum", sum, 32'd1);
    check("wrap_cnt", 32'(node_count), 32'd2);
    check("wrap_err", 32'(err), 32'd0);

    // Abort in the second payload read; a start during the walk must not be queued.
    @(negedge clk);
    start = 1'b1; head_addr = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; head_addr = 32'd30;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("ab_busy_pre", 32'(busy), 32'd1);
    check("ab_addr_pre", mem_addr, 32'd20);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    done_seen = 0;
    @(negedge clk);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_cnt", 32'(node_count), 32'd1);
    check("ab_sum", sum, 32'd5);
    check("ab_err", 32'(err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    check("ab_no_done", 32'(done_seen), 32'd0);

    walk(32'd10);
    check("fresh_done_cyc", 32'(done_cyc), 32'd7);
    check("fresh_sum", sum, 32'd21);

    // Reset mid-walk.
    @(negedge clk);
    start = 1'b1; head_addr = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_err", 32'(err), 32'd0);
    check("mr_cnt", 32'(node_count), 32'd0);
    check("mr_sum", sum, 32'd0);
    check("mr_addr", mem_addr, 32'd0);

    walk(32'd10);
    check("mr_post_cyc", 32'(done_cyc), 32'd7);
    check("mr_post_sum", sum, 32'd21);
    check("mr_post_cnt", 32'(node_count), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/list_walker.md
Name: list_walker

Overview:
- Sequencer that traverses a singly linked list stored in the shared asynchronous-read word memory and reduces it to a payload sum and node count.
- Sits between a host/testbench and the memory's addr/data port: drives mem_addr every cycle, samples mem_data in the same cycle, and follows next pointers.
- Node layout at node address p: mem[p] = payload, mem[p+1] = next-node address; next = 0 terminates the list.
- Includes a step limit (cycle/runaway guard) and an abort input.

Parameters:
- DATA_WIDTH, 32: memory word, address, pointer and sum width.
- MAX_NODES, 1024: maximum nodes visited before forced stop with error; must be ≥1.
- CNT_WIDTH, 16: node_count width; MAX_NODES must be < 2^CNT_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- head_addr  input  DATA_WIDTH  first node address; sampled with start.
- abort  input  1  stop traversal, return to IDLE, no done.
- mem_addr  output  DATA_WIDTH  registered address to memory.
- mem_data  input  DATA_WIDTH  combinational read data for the current mem_addr.
- busy  output  1  high in RD_PAY/RD_NEXT.
- done  output  1  one-cycle pulse in DONE.
- err  output  1  high when the last walk hit MAX_NODES; held until next accepted start.
- node_count  output  CNT_WIDTH  nodes visited in last/current walk.
- sum  output  DATA_WIDTH  payload sum mod 2^DATA_WIDTH.

Behaviour:
- Reset (rst_n=0 at clk edge, any state, including mid-walk): state=IDLE, mem_addr=0, busy=0, done=0, err=0, node_count=0, sum=0. Reset has priority over abort and start.
- States: IDLE, RD_PAY, RD_NEXT, DONE. busy and done are decoded from state and are glitch-free registered-state decodes.
- IDLE:
  - start=1 and head_addr≠0: clear sum/node_count/err, mem_addr<=head_addr, go to RD_PAY.
  - start=1 and head_addr=0: clear sum/node_count/err, go to DONE (empty list).
  - Otherwise hold; results stay stable.
- RD_PAY: sum<=sum+mem_data (wraps), mem_addr<=mem_addr+1 (wraps at 2^DATA_WIDTH), go to RD_NEXT.
- RD_NEXT: node_count<=node_count+1, then:
  - mem_data=0: go to DONE.
  - else if node_count+1=MAX_NODES: err<=1, go to DONE.
  - else: mem_addr<=mem_data, go to RD_PAY.
- DONE: done=1 for exactly one cycle, go to IDLE. mem_addr holds its last value.
- abort=1 in RD_PAY/RD_NEXT: go to IDLE next edge; sum/node_count keep partial values; err unchanged; no done pulse. abort in IDLE/DONE is ignored (DONE still pulses and completes).
- start while busy or in DONE: ignored, no queueing.
- Latency: for N≥1 nodes, done is high in cycle 2N+1 after the start-sampling edge, counting the first post-start cycle as 1; for the empty list it is cycle 1. Exactly one memory read per busy cycle.
- Self-loop (next=own address) or cyclic list: terminates via MAX_NODES with err=1 and node_count=MAX_NODES.
- Pointer to address 0 is always the terminator; a node at address 0 is unreachable except as head, and head_addr=0 means empty.

Test Plan:
- List at 10→20→30 (payloads 5,7,9; mem[11]=20, mem[21]=30, mem[31]=0), start with head=10 → done in cycle 7, sum=21, node_count=3, err=0; mem_addr sequence 10,11,20,21,30,31.
- head_addr=0 → done in cycle 1, sum=0, node_count=0, err=0, busy never high.
- Self-loop mem[40]=1, mem[41]=40, MAX_NODES=4 → done in cycle 9, node_count=4, sum=4, err=1.
- Payloads 0xFFFFFFFF and 2 in a two-node list → sum=1 (wrap), node_count=2.
- abort asserted in the 2nd RD_PAY of the 3-node list → IDLE next edge, no done, node_count=1, sum=5; start pulsed during the walk is ignored; a fresh start then yields sum=21.
- rst_n=0 for one edge mid-walk → all outputs 0, state IDLE; a subsequent start completes normally.
